// File: rtl/pulpissimo_rst_pkg.sv
// pulpissimo_rst_pkg: shared types and constants for the PULPissimo reset sequencer.
//   rst_state_e  sequencer FSM states
//   rst_cause_e  encoding of rst_cause_o
//   WARM_CNT_W   width of the saturating warm-reset counter
package pulpissimo_rst_pkg;

    typedef enum logic [1:0] {
        POR_WAIT,
        RELEASE,
        RUN,
        HOLD
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_SW  = 2'd1,
        CAUSE_BTN = 2'd2
    } rst_cause_e;

    localparam int WARM_CNT_W = 8;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert, sync-deassert reset synchroniser.
//   clk     clock the released reset is aligned to
//   rst_ni  raw active-low reset, asserts rst_no immediately
//   rst_no  synchronised active-low reset, rises SYNC_STAGES edges after rst_ni
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_ni,
    output logic rst_no
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign rst_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pulpissimo_rst_seq.sv
// pulpissimo_rst_seq: POR delay, staggered per-domain reset release and warm-reset handling.
//   ref_clk         reference clock
//   pad_reset_n     board reset, async active-low
//   sw_rst_req_i    single-cycle warm-reset request (ref_clk domain)
//   btn_rst_i       raw push-button, active-high, async
//   rst_n_o         per-domain active-low resets, bit 0 released first
//   ready_o         all domains released
//   rst_cause_o     cause of last reset (0 POR, 1 SW, 2 BTN)
//   warm_rst_cnt_o  saturating warm-reset count
module pulpissimo_rst_seq
    import pulpissimo_rst_pkg::*;
#(
    parameter int NUM_DOMAINS     = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int POR_CYCLES      = 64,
    parameter int STAGGER_CYCLES  = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                   ref_clk,
    input  logic                   pad_reset_n,
    input  logic                   sw_rst_req_i,
    input  logic                   btn_rst_i,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   ready_o,
    output logic [1:0]             rst_cause_o,
    output logic [WARM_CNT_W-1:0]  warm_rst_cnt_o
);

    localparam int CNT_W = $clog2(max4(POR_CYCLES, STAGGER_CYCLES, HOLD_CYCLES, DEBOUNCE_CYCLES) + 1);
    localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;

    logic                   int_rst_n;
    logic [1:0]             btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic                   armed_q, armed_d;
    logic                   btn_trig_q, btn_trig_d;
    logic                   sw_trig_q, sw_trig_d;
    logic                   btn_s, btn_fire, start_rel;
    rst_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   ready_q, ready_d;
    rst_cause_e             cause_q, cause_d;
    logic [WARM_CNT_W-1:0]  warm_q, warm_d;

    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk    (ref_clk),
        .rst_ni (pad_reset_n),
        .rst_no (int_rst_n)
    );

    // Triggers are registered so the FSM acts on them one edge later; the
    // button fires once per press and re-arms only after it is released.
    always_comb begin
        btn_s      = btn_sync_q[1];
        btn_sync_d = {btn_sync_q[0], btn_rst_i};
        btn_fire   = btn_s && armed_q && db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
        db_cnt_d   = !btn_s ? '0 : db_cnt_q == CNT_W'(DEBOUNCE_CYCLES) ? db_cnt_q : db_cnt_q + CNT_W'(1);
        armed_d    = !btn_s || (armed_q && !btn_fire);
        btn_trig_d = btn_fire;
        sw_trig_d  = sw_rst_req_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        cause_d = cause_q;
        warm_d  = warm_q;
        case (state_q)
            POR_WAIT: ;
            RELEASE: begin
                if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    rst_n_d = (rst_n_q << 1) | NUM_DOMAINS'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (sw_trig_q || btn_trig_q) begin
                    state_d = HOLD;
                    rst_n_d = '0;
                    ready_d = 1'b0;
                    cause_d = btn_trig_q ? CAUSE_BTN : CAUSE_SW;
                    warm_d  = warm_q + WARM_CNT_W'(warm_q != '1);
                end
            end
            HOLD: begin
                // Counter parks at its terminal value while the button is held.
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) cnt_d = cnt_q;
            end
        endcase
        start_rel = (state_q == POR_WAIT && cnt_q == CNT_W'(POR_CYCLES)) ||
                    (state_q == HOLD && cnt_q == CNT_W'(HOLD_CYCLES - 1) && !btn_s);
        if (start_rel) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = NUM_DOMAINS'(1);
        end
    end

    always_ff @(posedge ref_clk or negedge int_rst_n) begin
        if (!int_rst_n) begin
            btn_sync_q <= '0;
            db_cnt_q   <= '0;
            armed_q    <= 1'b0;
            btn_trig_q <= 1'b0;
            sw_trig_q  <= 1'b0;
            state_q    <= POR_WAIT;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            cause_q    <= CAUSE_POR;
            warm_q     <= '0;
        end else begin
            btn_sync_q <= btn_sync_d;
            db_cnt_q   <= db_cnt_d;
            armed_q    <= armed_d;
            btn_trig_q <= btn_trig_d;
            sw_trig_q  <= sw_trig_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            ready_q    <= ready_d;
            cause_q    <= cause_d;
            warm_q     <= warm_d;
        end
    end

    assign rst_n_o        = rst_n_q;
    assign ready_o        = ready_q;
    assign rst_cause_o    = cause_q;
    assign warm_rst_cnt_o = warm_q;

endmodule

// File: tb/tb_pulpissimo_rst_seq.sv
// tb_pulpissimo_rst_seq: scoreboard bench for pulpissimo_rst_seq with default parameters.
module tb_pulpissimo_rst_seq;

    typedef struct {
        int         c;
        logic [14:0] v;
    } rec_t;

    logic       ref_clk = 1'b0;
    logic       pad_reset_n;
    logic       sw_rst_req_i;
    logic       btn_rst_i;
    logic [3:0] rst_n_o;
    logic       ready_o;
    logic [1:0] rst_cause_o;
    logic [7:0] warm_rst_cnt_o;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          t0 = 0;
    int          wcnt = 0;
    rec_t        sb[$];
    rec_t        mon_e;
    logic [14:0] cur;
    logic [14:0] prev;
    bit          first = 1'b1;

    pulpissimo_rst_seq dut (
        .ref_clk        (ref_clk),
        .pad_reset_n    (pad_reset_n),
        .sw_rst_req_i   (sw_rst_req_i),
        .btn_rst_i      (btn_rst_i),
        .rst_n_o        (rst_n_o),
        .ready_o        (ready_o),
        .rst_cause_o    (rst_cause_o),
        .warm_rst_cnt_o (warm_rst_cnt_o)
    );

    always #4 ref_clk = ~ref_clk;

    // cyc holds the number of the last rising edge; at a falling edge it names
    // the edge whose results are being observed.
    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(int c, logic [3:0] r, logic rd, logic [1:0] ca, int n);
        rec_t e;
        e.c = c;
        e.v = {r, rd, ca, 8'(n)};
        sb.push_back(e);
    endtask

    task automatic push_rel(int s, logic [1:0] ca, int n);
        push(s,      4'b0001, 1'b0, ca, n);
        push(s + 16, 4'b0011, 1'b0, ca, n);
        push(s + 32, 4'b0111, 1'b0, ca, n);
        push(s + 48, 4'b1111, 1'b0, ca, n);
        push(s + 49, 4'b1111, 1'b1, ca, n);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge ref_clk);
    endtask

    task automatic por_release(bit full);
        #100;
        @(negedge ref_clk);
        pad_reset_n = 1'b1;
        t0 = cyc + 1;
        push(t0 + 66, 4'b0001, 1'b0, 2'd0, 0);
        push(t0 + 82, 4'b0011, 1'b0, 2'd0, 0);
        if (full) begin
            push(t0 + 98,  4'b0111, 1'b0, 2'd0, 0);
            push(t0 + 114, 4'b1111, 1'b0, 2'd0, 0);
            push(t0 + 115, 4'b1111, 1'b1, 2'd0, 0);
        end
    endtask

    task automatic pad_drop();
        @(posedge ref_clk);
        #2 pad_reset_n = 1'b0;
        wcnt = 0;
        push(cyc, 4'b0000, 1'b0, 2'd0, 0);
        #1 chk("async_drop", {27'd0, rst_n_o, ready_o}, 0);
    endtask

    task automatic sw_reset();
        int e;
        e = cyc + 1;
        wcnt = wcnt < 255 ? wcnt + 1 : 255;
        push(e + 1, 4'b0000, 1'b0, 2'd1, wcnt);
        push_rel(e + 33, 2'd1, wcnt);
        sw_rst_req_i = 1'b1;
        @(negedge ref_clk);
        sw_rst_req_i = 1'b0;
        wait_cyc(e + 83);
    endtask

    always @(negedge ref_clk) begin
        cur = {rst_n_o, ready_o, rst_cause_o, warm_rst_cnt_o};
        if (first || cur !== prev) begin
            first = 1'b0;
            prev  = cur;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got %h with no event expected (cycle %0d)", cur, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.c >= 0) chk("event_cycle", cyc, mon_e.c);
                chk("event_outputs", {17'd0, cur}, {17'd0, mon_e.v});
            end
        end
    end

    initial begin
        int b;
        pad_reset_n  = 1'b1;
        sw_rst_req_i = 1'b0;
        btn_rst_i    = 1'b0;
        #1 pad_reset_n = 1'b0;
        push(-1, 4'b0000, 1'b0, 2'd0, 0);
        #99;
        por_release(1'b1);
        wait_cyc(t0 + 120);

        sw_reset();

        btn_rst_i = 1'b1;
        repeat (5) @(negedge ref_clk);
        btn_rst_i = 1'b0;
        repeat (30) @(negedge ref_clk);

        b = cyc + 1;
        wcnt++;
        push(b + 10, 4'b0000, 1'b0, 2'd2, wcnt);
        push_rel(b + 202, 2'd2, wcnt);
        btn_rst_i = 1'b1;
        repeat (200) @(negedge ref_clk);
        btn_rst_i = 1'b0;
        wait_cyc(b + 257);

        b = cyc + 1;
        wcnt++;
        push(b + 10, 4'b0000, 1'b0, 2'd2, wcnt);
        push_rel(b + 42, 2'd2, wcnt);
        btn_rst_i = 1'b1;
        repeat (9) @(negedge ref_clk);
        sw_rst_req_i = 1'b1;
        @(negedge ref_clk);
        sw_rst_req_i = 1'b0;
        repeat (3) @(negedge ref_clk);
        btn_rst_i = 1'b0;
        wait_cyc(b + 50);
        sw_rst_req_i = 1'b1;
        @(negedge ref_clk);
        sw_rst_req_i = 1'b0;
        wait_cyc(b + 97);

        pad_drop();
        por_release(1'b0);
        wait_cyc(t0 + 90);
        pad_drop();
        por_release(1'b1);
        wait_cyc(t0 + 120);

        repeat (260) sw_reset();

        repeat (20) @(negedge ref_clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
